// File: rtl/multibyte_adder_seq.sv
// Sequential multi-byte unsigned adder: one byte pair per clock, LSB first,
// through a single 8-bit adder with its carry-in tied low.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module multibyte_adder_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES:0]   out_sum,
  output logic                busy
);
  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q, b_q, res, res_next;
  logic [W:0]    sum_q;
  logic [7:0]    a_byte, b_byte, s_lo;
  logic          s_hi;
  logic [8:0]    t;

  // Byte select / byte write via constant-index loop keeps part-selects static.
  always_comb begin
    a_byte   = '0;
    b_byte   = '0;
    res_next = res;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
        res_next[i*8 +: 8] = t[7:0];
      end
    end
  end

  adder_8bit u_add (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (1'b0),
    .sum  (s_lo),
    .cout (s_hi)
  );

  // Byte carry is folded in after the adder since its carry-in is unused.
  assign t = {s_hi, s_lo} + {8'd0, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      sum_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            idx   <= '0;
            carry <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= t[8];
          if (idx == LAST) begin
            sum_q <= {t[8], res_next};
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_sum   = sum_q;

endmodule
